// File: rtl/prog_seq_pkg.sv
// -----------------------------------------------------------------------------
// prog_seq_pkg
// Shared definitions for the program sequencer: default sizing, the FSM state
// encoding and a helper that sizes the word counter.
//   DEF_DEPTH   default instruction-memory depth (words)
//   DEF_RUN_W   default width of the run-length counter
//   seq_state_t sequencer FSM states
//   cnt_width   bits needed to count 0..depth inclusive
// -----------------------------------------------------------------------------
package prog_seq_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_RUN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_GAP  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // word_count has to represent DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// -----------------------------------------------------------------------------
// prog_sequencer_if
// Bundles the loader handshake, run control and processor-side signals of the
// program sequencer.
//   master : loader / controller side (drives ld_*, run_cycles, abort)
//   slave  : sequencer side (drives ld_ready, mem_*, working, done,
//            word_count, err_overflow)
// -----------------------------------------------------------------------------
interface prog_sequencer_if #(
    parameter int DEPTH = prog_seq_pkg::DEF_DEPTH,
    parameter int RUN_W = prog_seq_pkg::DEF_RUN_W
);
    localparam int CNT_W = prog_seq_pkg::cnt_width(DEPTH);

    // loader handshake
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             ld_ready;
    // run control
    logic [RUN_W-1:0] run_cycles;
    logic             abort;
    // processor side
    logic [31:0]      mem_addr;
    logic             mem_wr;
    logic [31:0]      mem_wdata;
    logic             working;
    logic             done;
    // status
    logic [CNT_W-1:0] word_count;
    logic             err_overflow;

    modport master (
        output ld_valid, ld_data, ld_last, run_cycles, abort,
        input  ld_ready, mem_addr, mem_wr, mem_wdata, working, done,
               word_count, err_overflow
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, run_cycles, abort,
        output ld_ready, mem_addr, mem_wr, mem_wdata, working, done,
               word_count, err_overflow
    );

endinterface

// File: rtl/run_timer.sv
// -----------------------------------------------------------------------------
// run_timer
// Run-length counter for the sequencer. The limit is captured on load; while
// enabled the counter advances once per cycle and expired flags the final
// enabled cycle of a run. A limit of zero never expires.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture limit_in and restart the count
//   limit_in     : requested run length in cycles (0 = unbounded)
//   enable       : the sequencer is in its run state this cycle
//   expired      : this enabled cycle is the last one of the run
// -----------------------------------------------------------------------------
module run_timer
    import prog_seq_pkg::*;
#(
    parameter int RUN_W = DEF_RUN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [RUN_W-1:0] limit_in,
    input  logic             enable,
    output logic             expired
);

    logic [RUN_W-1:0] count_reg;
    logic [RUN_W-1:0] limit_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
            limit_reg <= limit_in;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the number of run cycles already completed, so the run
    // ends on the cycle where it equals limit-1.
    assign expired = enable && (limit_reg != '0) && (count_reg == limit_reg - 1'b1);

endmodule

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
// Loads a program word-by-word into a processor instruction memory, then runs
// the processor for a programmed number of cycles (or until aborted).
//   clock : single clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : prog_sequencer_if.slave
//           ld_valid/ld_data/ld_last/ld_ready  loader handshake
//           run_cycles, abort                  run control
//           mem_addr/mem_wr/mem_wdata          registered memory write port
//           working, done                      processor enable / end pulse
//           word_count, err_overflow           load status
// Processor-side outputs are registered and trail the FSM by one cycle, so the
// GAP state shows up as one quiet cycle between the final write and working.
// -----------------------------------------------------------------------------
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int RUN_W = DEF_RUN_W
) (
    input  logic            clock,
    input  logic            reset,
    prog_sequencer_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] word_count_reg, word_count_next;
    logic             err_overflow_reg, err_overflow_next;
    logic             mem_wr_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic             working_reg;
    logic             done_reg;

    logic ld_ready;
    logic xfer;
    logic load_full;
    logic timer_load;
    logic timer_en;
    logic timer_expired;

    assign ld_ready  = ((state_reg == ST_IDLE) || (state_reg == ST_LOAD))
                       && (word_count_reg < CNT_W'(DEPTH));
    assign xfer      = bus.ld_valid && ld_ready;
    // the word being accepted now is the last slot of the memory
    assign load_full = (word_count_reg == CNT_W'(DEPTH - 1));

    run_timer #(
        .RUN_W (RUN_W)
    ) u_run_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .limit_in (bus.run_cycles),
        .enable   (timer_en),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next        = state_reg;
        word_count_next   = word_count_reg;
        err_overflow_next = err_overflow_reg;
        timer_load        = 1'b0;
        timer_en          = 1'b0;
        case (state_reg)
            ST_IDLE, ST_LOAD: begin
                if (xfer) begin
                    word_count_next = word_count_reg + 1'b1;
                end
                // abort wins over a simultaneous transfer: the word is still
                // written, but the program is discarded
                if (bus.abort) begin
                    state_next      = ST_IDLE;
                    word_count_next = '0;
                end else if (xfer) begin
                    if (bus.ld_last) begin
                        state_next = ST_GAP;
                    end else if (load_full) begin
                        state_next        = ST_GAP;
                        err_overflow_next = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                timer_load = 1'b1;
                if (bus.abort) begin
                    state_next      = ST_IDLE;
                    word_count_next = '0;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_en = 1'b1;
                if (bus.abort || timer_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next      = ST_IDLE;
                word_count_next = '0;
            end
            default: begin
                state_next      = ST_IDLE;
                word_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            word_count_reg   <= '0;
            err_overflow_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            word_count_reg   <= word_count_next;
            err_overflow_reg <= err_overflow_next;
        end
    end

    // Processor-side outputs: address/data are forced to zero on every cycle
    // without a transfer so the bus is quiet in GAP, RUN and DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            working_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            mem_wr_reg    <= xfer;
            mem_addr_reg  <= xfer ? 32'(word_count_reg) : 32'd0;
            mem_wdata_reg <= xfer ? bus.ld_data : 32'd0;
            working_reg   <= (state_reg == ST_RUN);
            done_reg      <= (state_reg == ST_DONE);
        end
    end

    assign bus.ld_ready     = ld_ready;
    assign bus.mem_wr       = mem_wr_reg;
    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_wdata    = mem_wdata_reg;
    assign bus.working      = working_reg;
    assign bus.done         = done_reg;
    assign bus.word_count   = word_count_reg;
    assign bus.err_overflow = err_overflow_reg;

endmodule
